ctrl_multi: RTL and testbench
=============================

# ctrl_multi

Parametrised multicycle control FSM for the SISC datapath, and the successor to the ALU-only sequencer. It decodes the full instruction set: ALU ops, LOD/STR with a data-memory request/acknowledge handshake, SWP with a two-register writeback, and conditional branches (absolute and relative). It also provides a hardware halt state, an error flag for memory timeouts, and a retired-instruction counter. It sits between the instruction register/status register and the PC, register file, ALU, data memory and writeback mux.

## Interface
Parameters:
- STAT_W, 4, width of `stat` and `mm`; `mm` is the branch condition mask.
- ACK_TO, 15, maximum cycles spent in MEM waiting for `dm_ack` before error.
- ICNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_f  in  1  synchronous active-low reset, sampled on posedge clk.
- opcode  in  4  IR[31:28]; NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15.
- mm  in  STAT_W  IR mode/mask field.
- stat  in  STAT_W  status register {C,V,N,Z}.
- dm_ack  in  1  data-memory acknowledge.
- rf_we  out  1  register-file write enable.
- wb_sel  out  1  1 = write memory data, 0 = ALU result.
- alu_op  out  2  ALU control.
- br_sel  out  1  1 = absolute target, 0 = PC-relative.
- pc_sel  out  1  1 = branch target, 0 = PC+1.
- pc_write  out  1  PC load enable.
- pc_rst  out  1  PC clear.
- ir_load  out  1  IR load enable.
- rb_sel  out  1  selects the rs field as register-file read port B / write address.
- dm_req  out  1  data-memory request.
- dm_we  out  1  data-memory write.
- halted  out  1  FSM is in HALT.
- err  out  1  sticky memory-timeout flag.
- icount  out  ICNT_W  retired instructions, wraps modulo 2^ICNT_W.

## Operation
- States and transitions:
  - START → FETCH.
  - FETCH → DECODE.
  - DECODE → HALT if opcode=HLT, else EXECUTE.
  - EXECUTE → MEM.
  - MEM → WRITEBACK when no request is pending, or when dm_ack=1. MEM → HALT with err=1 when dm_ack has been low for ACK_TO consecutive MEM cycles.
  - WRITEBACK → WB2 if SWP, else FETCH.
  - WB2 → FETCH.
  - HALT → HALT.
  - Undefined encodings → START.
- Output defaults: alu_op=2'b10; all other single-bit outputs 0.
- START: pc_rst=1.
- FETCH: ir_load=1, pc_write=1, pc_sel=0.
- EXECUTE:
  - ALU_OP: alu_op=00 if mm=0; alu_op=01 if mm[STAT_W-1]=1.
  - LOD/STR: alu_op=01 (address = base + immediate).
  - Branch condition, all branch opcodes: hit = (mm & stat) != 0 or mm == 0.
  - BRA/BRR: taken = hit. BNE/BNR: taken = !hit.
  - Taken branch: pc_write=1, pc_sel=1. br_sel=1 for BRA/BNE, 0 for BRR/BNR, in EXECUTE regardless of taken.
- MEM:
  - ALU_OP: alu_op=10 if mm=0; alu_op=11 if mm[STAT_W-1]=1.
  - LOD/STR: dm_req=1 and alu_op=01. STR also asserts dm_we=1 and rb_sel=1.
  - dm_req, dm_we and the address are held stable until dm_ack.
- WRITEBACK:
  - ALU_OP: rf_we=1.
  - LOD: rf_we=1, wb_sel=1.
  - SWP: rf_we=1 (writes rd with rs).
  - NOOP, branches, STR: rf_we=0.
- WB2 (SWP only): rf_we=1, rb_sel=1 (writes rs with the old rd).
- icount increments by 1 on each transition into FETCH from WRITEBACK or WB2.
- Unlisted opcodes (9–14) are treated as NOOP. They retire normally.

## Timing
- Reset: when rst_f=0 at a posedge, the next state is START and the timeout counter, err and icount are cleared. This holds from any state, including mid-MEM and HALT.
- Output values while in START: pc_rst=1, alu_op=10, all other outputs 0, icount=0.
- Outputs are combinational from the state and the IR fields.
- opcode and mm are stable from DECODE onward.
- stat is sampled in EXECUTE.
- Latency:
  - ALU, NOOP, branch: 5 cycles (FETCH..WRITEBACK).
  - SWP: 6 cycles.
  - LOD/STR: 5 + n cycles, where n is the number of MEM cycles with dm_ack=0. If dm_ack=1 in the first MEM cycle, n=0.
- A dm_ack outside MEM, or during an ALU-op MEM cycle, is ignored.
- Timeout counter: cleared on entry to MEM, increments each MEM cycle while dm_ack=0. If dm_ack=1 arrives in the same cycle the count reaches ACK_TO, the ack wins.
- HLT: halted=1 from the cycle after DECODE. No further pc_write or rf_we until reset. icount does not count HLT.

## Test plan
- Reset, then issue ALU add (opcode 8, mm 0): rf_we=1 only in cycle 5; alu_op sequence 10,10,00,10,10; icount=1 on return to FETCH.
- BNE with stat=4'b0001, mm=4'b0001: branch not taken, pc_write=0 in EXECUTE. Same instruction with stat=0: taken, pc_write=1, pc_sel=1, br_sel=1.
- LOD with dm_ack held low for 3 cycles: MEM lasts 4 cycles with dm_req high throughout; then rf_we=1, wb_sel=1; total 8 cycles.
- STR with dm_ack never asserted, ACK_TO=15: after 15 MEM cycles → HALT, err=1, halted=1.
- SWP: rf_we high in two consecutive cycles, rb_sel=0 then 1.
- rst_f=0 mid-MEM, then HLT at 2^ICNT_W-wrap: state returns to START and all outputs match their START values; icount wraps from max to 0 and does not advance on HLT.

Source files
------------

// File: rtl/ctrl_multi_if.sv
// Control bundle between the SISC multicycle sequencer and the datapath:
// IR/status/memory-ack inputs in, datapath control strobes out.
interface ctrl_multi_if #(
  parameter int unsigned STAT_W = 4,
  parameter int unsigned ICNT_W = 16
) ();
  logic [3:0]        opcode;
  logic [STAT_W-1:0] mm;
  logic [STAT_W-1:0] stat;
  logic              dm_ack;

  logic              rf_we;
  logic              wb_sel;
  logic [1:0]        alu_op;
  logic              br_sel;
  logic              pc_sel;
  logic              pc_write;
  logic              pc_rst;
  logic              ir_load;
  logic              rb_sel;
  logic              dm_req;
  logic              dm_we;
  logic              halted;
  logic              err;
  logic [ICNT_W-1:0] icount;

  // Sequencer side.
  modport slave (
    input  opcode, mm, stat, dm_ack,
    output rf_we, wb_sel, alu_op, br_sel, pc_sel, pc_write, pc_rst, ir_load,
           rb_sel, dm_req, dm_we, halted, err, icount
  );

  // Datapath / environment side.
  modport master (
    output opcode, mm, stat, dm_ack,
    input  rf_we, wb_sel, alu_op, br_sel, pc_sel, pc_write, pc_rst, ir_load,
           rb_sel, dm_req, dm_we, halted, err, icount
  );
endinterface

// File: rtl/ctrl_multi.sv
// Multicycle control FSM for the SISC datapath: ALU, load/store with ack handshake,
// swap, conditional branches, halt, memory-timeout error and retired-instruction count.
module ctrl_multi #(
  parameter int unsigned STAT_W = 4,
  parameter int unsigned ACK_TO = 15,
  parameter int unsigned ICNT_W = 16
) (
  input logic         clk,
  input logic         rst_f,
  ctrl_multi_if.slave ctl_io
);

  localparam int unsigned ToW = $clog2(ACK_TO + 1);

  localparam logic [3:0] OpNoop = 4'd0;
  localparam logic [3:0] OpLod  = 4'd1;
  localparam logic [3:0] OpStr  = 4'd2;
  localparam logic [3:0] OpSwp  = 4'd3;
  localparam logic [3:0] OpBra  = 4'd4;
  localparam logic [3:0] OpBrr  = 4'd5;
  localparam logic [3:0] OpBne  = 4'd6;
  localparam logic [3:0] OpBnr  = 4'd7;
  localparam logic [3:0] OpAlu  = 4'd8;
  localparam logic [3:0] OpHlt  = 4'd15;

  typedef enum logic [2:0] {
    StStart,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback,
    StWb2,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              err_q, err_d;
  logic [ICNT_W-1:0] icount_q, icount_d;

  // Instruction decode.
  logic is_alu, is_lod, is_str, is_swp, is_mem, is_br, br_abs, br_inv;
  logic mm_zero, mm_msb, hit, taken;

  always_comb begin
    is_alu  = (ctl_io.opcode == OpAlu);
    is_lod  = (ctl_io.opcode == OpLod);
    is_str  = (ctl_io.opcode == OpStr);
    is_swp  = (ctl_io.opcode == OpSwp);
    is_mem  = is_lod | is_str;
    is_br   = (ctl_io.opcode == OpBra) | (ctl_io.opcode == OpBrr) |
              (ctl_io.opcode == OpBne) | (ctl_io.opcode == OpBnr);
    br_abs  = (ctl_io.opcode == OpBra) | (ctl_io.opcode == OpBne);
    br_inv  = (ctl_io.opcode == OpBne) | (ctl_io.opcode == OpBnr);
    mm_zero = (ctl_io.mm == '0);
    mm_msb  = ctl_io.mm[STAT_W-1];
    // An all-zero mask means "always".
    hit     = ((ctl_io.mm & ctl_io.stat) != '0) | mm_zero;
    taken   = is_br & (hit ^ br_inv);
  end

  // Next state, timeout counter, error flag and retire counter.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
    icount_d = icount_q;
    case (state_q)
      StStart:  state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = (ctl_io.opcode == OpHlt) ? StHalt : StExecute;
      StExecute: begin
        state_d  = StMem;
        to_cnt_d = '0;
      end
      StMem: begin
        // An ack in the same cycle the count would expire takes priority.
        if (!is_mem || ctl_io.dm_ack) begin
          state_d = StWriteback;
        end else if (to_cnt_q == ToW'(ACK_TO - 1)) begin
          state_d  = StHalt;
          err_d    = 1'b1;
          to_cnt_d = ToW'(ACK_TO);
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StWriteback: begin
        if (is_swp) begin
          state_d = StWb2;
        end else begin
          state_d  = StFetch;
          icount_d = icount_q + ICNT_W'(1);
        end
      end
      StWb2: begin
        state_d  = StFetch;
        icount_d = icount_q + ICNT_W'(1);
      end
      StHalt:  state_d = StHalt;
      default: state_d = StStart;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q  <= StStart;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
      icount_q <= icount_d;
    end
  end

  // Datapath controls, combinational from state and IR fields.
  always_comb begin
    ctl_io.rf_we    = 1'b0;
    ctl_io.wb_sel   = 1'b0;
    ctl_io.alu_op   = 2'b10;
    ctl_io.br_sel   = 1'b0;
    ctl_io.pc_sel   = 1'b0;
    ctl_io.pc_write = 1'b0;
    ctl_io.pc_rst   = 1'b0;
    ctl_io.ir_load  = 1'b0;
    ctl_io.rb_sel   = 1'b0;
    ctl_io.dm_req   = 1'b0;
    ctl_io.dm_we    = 1'b0;
    ctl_io.halted   = 1'b0;
    case (state_q)
      StStart: ctl_io.pc_rst = 1'b1;
      StFetch: begin
        ctl_io.ir_load  = 1'b1;
        ctl_io.pc_write = 1'b1;
        ctl_io.pc_sel   = 1'b0;
      end
      StExecute: begin
        if (is_alu) begin
          if (mm_zero)     ctl_io.alu_op = 2'b00;
          else if (mm_msb) ctl_io.alu_op = 2'b01;
        end
        if (is_mem) ctl_io.alu_op = 2'b01;
        if (is_br)  ctl_io.br_sel = br_abs;
        if (taken) begin
          ctl_io.pc_write = 1'b1;
          ctl_io.pc_sel   = 1'b1;
        end
      end
      StMem: begin
        if (is_alu) begin
          if (mm_zero)     ctl_io.alu_op = 2'b10;
          else if (mm_msb) ctl_io.alu_op = 2'b11;
        end
        // Request, write strobe and address stay put until the ack.
        if (is_mem) begin
          ctl_io.dm_req = 1'b1;
          ctl_io.alu_op = 2'b01;
        end
        if (is_str) begin
          ctl_io.dm_we  = 1'b1;
          ctl_io.rb_sel = 1'b1;
        end
      end
      StWriteback: begin
        ctl_io.rf_we  = is_alu | is_lod | is_swp;
        ctl_io.wb_sel = is_lod;
      end
      StWb2: begin
        ctl_io.rf_we  = 1'b1;
        ctl_io.rb_sel = 1'b1;
      end
      StHalt:  ctl_io.halted = 1'b1;
      default: ;
    endcase
  end

  assign ctl_io.err    = err_q;
  assign ctl_io.icount = icount_q;

endmodule

// File: tb/tb_ctrl_multi.sv
// Scoreboard bench for ctrl_multi: the stimulus queues per-cycle expected controls,
// a negedge monitor pops and compares against the DUT.
module tb_ctrl_multi;

  typedef struct packed {
    logic       rf_we;
    logic       wb_sel;
    logic [1:0] alu_op;
    logic       br_sel;
    logic       pc_sel;
    logic       pc_write;
    logic       pc_rst;
    logic       ir_load;
    logic       rb_sel;
    logic       dm_req;
    logic       dm_we;
    logic       halted;
    logic       err;
    logic [3:0] icount;
  } exp_t;

  logic clk = 1'b0;
  logic rst_f;

  ctrl_multi_if #(.STAT_W(4), .ICNT_W(4)) bus ();

  ctrl_multi #(.STAT_W(4), .ACK_TO(15), .ICNT_W(4)) dut (
    .clk    (clk),
    .rst_f  (rst_f),
    .ctl_io (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  string      name_q[$];
  int         vectors = 0;
  int         errors  = 0;
  logic [3:0] ic      = 4'd0;

  always @(negedge clk) begin : monitor
    exp_t  a, e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {bus.rf_we, bus.wb_sel, bus.alu_op, bus.br_sel, bus.pc_sel, bus.pc_write,
           bus.pc_rst, bus.ir_load, bus.rb_sel, bus.dm_req, bus.dm_we, bus.halted,
           bus.err, bus.icount};
      vectors++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %p want %p", n, a, e);
      end
    end
  end

  function automatic exp_t base();
    exp_t e = '0;
    e.alu_op = 2'b10;
    e.icount = ic;
    return e;
  endfunction

  function automatic exp_t st_start();
    exp_t e = '0;
    e.alu_op = 2'b10;
    e.pc_rst = 1'b1;
    return e;
  endfunction

  task automatic cyc(input string name, input exp_t e, input logic ack);
    bus.dm_ack = ack;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st);
    bus.opcode = op;
    bus.mm     = mm;
    bus.stat   = st;
  endtask

  task automatic fetch_decode(input string tag);
    exp_t e;
    e = base(); e.ir_load = 1'b1; e.pc_write = 1'b1;
    cyc({tag, "_fetch"}, e, 1'b0);
    cyc({tag, "_decode"}, base(), 1'b0);
  endtask

  // Instruction with a single MEM cycle: explicit EXECUTE/MEM/WRITEBACK expectations.
  task automatic simple(input string tag, input exp_t ex, input exp_t mem, input exp_t wb);
    fetch_decode(tag);
    cyc({tag, "_exec"}, ex, 1'b0);
    cyc({tag, "_mem"}, mem, 1'b0);
    cyc({tag, "_wb"}, wb, 1'b0);
    ic = ic + 4'd1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of stimulus");
    $fatal(1);
  end

  initial begin : stim
    exp_t ex, mem, wb;
    rst_f = 1'b0;
    set_ir(4'd0, 4'd0, 4'd0);
    bus.dm_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_f = 1'b1;
    cyc("start", st_start(), 1'b0);

    // ALU add: alu_op 10,10,00,10,10, rf_we only in writeback.
    set_ir(4'd8, 4'd0, 4'd0);
    ex = base(); ex.alu_op = 2'b00;
    mem = base();
    wb = base(); wb.rf_we = 1'b1;
    simple("alu_add", ex, mem, wb);

    // ALU with mask MSB set: 01 in EXECUTE, 11 in MEM.
    set_ir(4'd8, 4'b1000, 4'd0);
    ex = base(); ex.alu_op = 2'b01;
    mem = base(); mem.alu_op = 2'b11;
    wb = base(); wb.rf_we = 1'b1;
    simple("alu_msb", ex, mem, wb);

    // BNE, condition hit: not taken.
    set_ir(4'd6, 4'b0001, 4'b0001);
    ex = base(); ex.br_sel = 1'b1;
    simple("bne_nt", ex, base(), base());

    // BNE, condition miss: taken, absolute.
    set_ir(4'd6, 4'b0001, 4'b0000);
    ex = base(); ex.br_sel = 1'b1; ex.pc_write = 1'b1; ex.pc_sel = 1'b1;
    simple("bne_tk", ex, base(), base());

    // BRR with mm=0 is unconditional, relative target.
    set_ir(4'd5, 4'b0000, 4'b0000);
    ex = base(); ex.pc_write = 1'b1; ex.pc_sel = 1'b1;
    simple("brr_tk", ex, base(), base());

    // LOD, ack low for 3 MEM cycles; stray ack in EXECUTE is ignored.
    set_ir(4'd1, 4'd0, 4'd0);
    fetch_decode("lod");
    ex = base(); ex.alu_op = 2'b01;
    cyc("lod_exec", ex, 1'b1);
    mem = base(); mem.alu_op = 2'b01; mem.dm_req = 1'b1;
    for (int k = 0; k < 4; k++) cyc($sformatf("lod_mem%0d", k), mem, (k == 3));
    wb = base(); wb.rf_we = 1'b1; wb.wb_sel = 1'b1;
    cyc("lod_wb", wb, 1'b0);
    ic = ic + 4'd1;

    // SWP: two consecutive writebacks, rb_sel 0 then 1.
    set_ir(4'd3, 4'd0, 4'd0);
    fetch_decode("swp");
    cyc("swp_exec", base(), 1'b0);
    cyc("swp_mem", base(), 1'b0);
    wb = base(); wb.rf_we = 1'b1;
    cyc("swp_wb", wb, 1'b0);
    wb.rb_sel = 1'b1;
    cyc("swp_wb2", wb, 1'b0);
    ic = ic + 4'd1;

    // STR, ack arrives on the 15th MEM cycle: ack beats the timeout.
    set_ir(4'd2, 4'd0, 4'd0);
    fetch_decode("str_late");
    ex = base(); ex.alu_op = 2'b01;
    cyc("str_late_exec", ex, 1'b0);
    mem = base(); mem.alu_op = 2'b01; mem.dm_req = 1'b1; mem.dm_we = 1'b1; mem.rb_sel = 1'b1;
    for (int k = 0; k < 15; k++) cyc($sformatf("str_late_mem%0d", k), mem, (k == 14));
    cyc("str_late_wb", base(), 1'b0);
    ic = ic + 4'd1;

    // Unlisted opcode behaves as NOOP and retires.
    set_ir(4'd11, 4'd0, 4'd0);
    simple("op11", base(), base(), base());

    // Reset in the middle of a LOD wait.
    set_ir(4'd1, 4'd0, 4'd0);
    fetch_decode("lod_rst");
    ex = base(); ex.alu_op = 2'b01;
    cyc("lod_rst_exec", ex, 1'b0);
    mem = base(); mem.alu_op = 2'b01; mem.dm_req = 1'b1;
    cyc("lod_rst_mem0", mem, 1'b0);
    rst_f = 1'b0;
    cyc("lod_rst_mem1", mem, 1'b0);
    rst_f = 1'b1;
    ic = 4'd0;
    cyc("start_mid_mem", st_start(), 1'b0);

    // Sixteen NOOPs wrap the 4-bit retire counter 15 -> 0.
    set_ir(4'd0, 4'd0, 4'd0);
    for (int k = 0; k < 16; k++) simple($sformatf("noop%0d", k), base(), base(), base());

    // HLT: halted from the cycle after DECODE, count frozen, acks ignored.
    set_ir(4'd15, 4'd0, 4'd0);
    fetch_decode("hlt");
    ex = base(); ex.halted = 1'b1;
    for (int k = 0; k < 3; k++) cyc($sformatf("hlt_halt%0d", k), ex, k[0]);
    rst_f = 1'b0;
    cyc("hlt_rst", ex, 1'b0);
    rst_f = 1'b1;
    cyc("start_after_hlt", st_start(), 1'b0);

    // STR with no ack ever: 15 MEM cycles then HALT with err.
    set_ir(4'd2, 4'd0, 4'd0);
    fetch_decode("str_to");
    ex = base(); ex.alu_op = 2'b01;
    cyc("str_to_exec", ex, 1'b0);
    for (int k = 0; k < 15; k++) cyc($sformatf("str_to_mem%0d", k), mem_str(), 1'b0);
    ex = base(); ex.halted = 1'b1; ex.err = 1'b1;
    cyc("str_to_halt0", ex, 1'b0);
    cyc("str_to_halt1", ex, 1'b1);
    rst_f = 1'b0;
    cyc("str_to_rst", ex, 1'b0);
    rst_f = 1'b1;
    cyc("start_err_clr", st_start(), 1'b0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  function automatic exp_t mem_str();
    exp_t e = base();
    e.alu_op = 2'b01;
    e.dm_req = 1'b1;
    e.dm_we  = 1'b1;
    e.rb_sel = 1'b1;
    return e;
  endfunction

endmodule
